alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a WIDTH parameter, XOR and iterative multiply ops, and a full flag set (zero, carry, negative, overflow, illegal-op).
- Uses valid/ready handshakes on both input and output, so it can sit between pipelined producers and consumers and absorb back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- A  input  WIDTH  operand A, unsigned/two's complement.
- B  input  WIDTH  operand B.
- sel  input  3  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  carry/borrow/unsigned multiply overflow.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal  output  1  opcode 3'b111 was issued.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; out_valid, result, all flags, busy and counter go to 0.
  - An in-flight multiply is discarded.
  - in_ready is 0 while rst_n is low.
- Opcodes:
  - 000 ADD: {carry,result}=A+B.
  - 001 SUB: result=A-B; carry=1 when A<B unsigned (borrow).
  - 010 AND; 011 OR; 100 ANDN (A&~B); 101 XOR.
  - 110 MUL: unsigned; result=low WIDTH bits of A*B; carry=1 if any high product bit is nonzero.
  - 111: result=0, illegal=1.
- Flags:
  - zero and negative always derive from the registered result.
  - overflow is set only for ADD/SUB, using standard sign rules; 0 for every other op.
  - carry is 0 for logic ops and opcode 111.
  - illegal is 0 for opcodes 000-110.
  - Flags update only together with result.
- Handshake:
  - in_ready = (state==IDLE) && rst_n && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready at an edge.
  - Output transfer occurs when out_valid && out_ready.
  - result and flags hold stable while out_valid && !out_ready.
- States:
  - IDLE:
    - On accept of opcodes 000-101 or 111: load result/flags and set out_valid at the same edge. Latency 1 cycle; full throughput of one op per cycle when out_ready is held high.
    - On accept of 110: latch A, B; clear accumulator; cnt=WIDTH; busy=1; go to MUL. If the old result is consumed at the same edge, out_valid falls.
  - MUL:
    - Each edge: if the current multiplier LSB is 1, add the multiplicand to a 2*WIDTH accumulator. Shift the multiplicand left and the multiplier right; cnt decrements.
    - When cnt reaches 1, that edge writes result/flags, sets out_valid, clears busy and returns to IDLE.
    - Result is visible WIDTH+1 cycles after the accept cycle.
    - in_ready=0 and in_valid is ignored throughout MUL.
- Output clear: out_valid falls on an output transfer unless a new single-cycle op is accepted at the same edge, in which case it stays 1 with the new data.
- Boundaries:
  - ADD and SUB wrap modulo 2^WIDTH.
  - MUL by 0 still takes WIDTH iterations.
  - A reset during MUL aborts cleanly with no stale result.
  - in_valid may drop without having been accepted; no state effect.

Test Plan (WIDTH=8):
- Reset mid-MUL: accept 0x14*0x14, then pull rst_n low at iteration 3 -> next cycle out_valid=0, busy=0, in_ready=1 after rst_n high; a following ADD 1+1 returns 0x02.
- ADD 0xC8+0x64 -> result 0x2C, carry=1, overflow=0. ADD 0x64+0x64 -> 0xC8, negative=1, overflow=1, carry=0. Both with out_valid one cycle after accept.
- SUB 0x03-0x08 -> 0xFB, carry=1, negative=1. SUB 0x05-0x05 -> 0x00, zero=1, carry=0.
- Back-to-back AND/OR/ANDN/XOR on 0xCC, 0xAA with out_ready=1 -> 0x88, 0xEE, 0x44, 0x66 on consecutive cycles; in_ready stays 1.
- MUL 0x0D*0x0B -> 0x8F, carry=0, busy high 8 cycles, in_ready=0 throughout, out_valid 9 cycles after accept. MUL 0x14*0x14 -> 0x90, carry=1.
- Back-pressure: hold out_ready=0 after an OR -> result/flags stable, in_ready=0. Issue op 111 after release -> result 0x00, zero=1, illegal=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The ALU side uses the slave modport; the producer/consumer side uses master.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, result,
        input  zero, carry, negative, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, result,
        output zero, carry, negative, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides.
// Single-cycle ops complete at the accept edge; MUL iterates WIDTH edges.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic               ovalid_q, ovalid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_ready;
    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nx;

    logic               wr;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_ill;

    assign in_ready = (state_q == IDLE) && rst_n
                      && (!ovalid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff = {1'b0, bus.A} - {1'b0, bus.B};

    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        ovalid_d = ovalid_q && !bus.out_ready;
        busy_d   = busy_q;
        res_d    = res_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        wr       = 1'b0;
        w_res    = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept && bus.sel == OP_MUL) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = MUL;
                end else if (accept) begin
                    wr = 1'b1;
                    unique case (bus.sel)
                        OP_ADD: begin
                            w_res   = sum[WIDTH-1:0];
                            w_carry = sum[WIDTH];
                            w_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
                                      && (sum[WIDTH-1] != bus.A[WIDTH-1]);
                        end
                        OP_SUB: begin
                            w_res   = diff[WIDTH-1:0];
                            w_carry = diff[WIDTH];
                            w_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1])
                                      && (diff[WIDTH-1] != bus.A[WIDTH-1]);
                        end
                        OP_AND:  w_res = bus.A & bus.B;
                        OP_OR:   w_res = bus.A | bus.B;
                        OP_ANDN: w_res = bus.A & ~bus.B;
                        OP_XOR:  w_res = bus.A ^ bus.B;
                        OP_MUL:  w_res = '0;
                        OP_ILL:  w_ill = 1'b1;
                    endcase
                end
            end
            MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                // Last iteration folds straight into the result register
                if (cnt_q == CNT_W'(1)) begin
                    wr      = 1'b1;
                    w_res   = acc_nx[WIDTH-1:0];
                    w_carry = |acc_nx[2*WIDTH-1:WIDTH];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        if (wr) begin
            ovalid_d = 1'b1;
            res_d    = w_res;
            zero_d   = (w_res == '0);
            neg_d    = w_res[WIDTH-1];
            carry_d  = w_carry;
            ovf_d    = w_ovf;
            ill_d    = w_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ovalid_q <= ovalid_d;
            busy_q   <= busy_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ovalid_q;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8.
// Flags are compared as {out_valid,zero,carry,negative,overflow,illegal,busy}.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] flags();
        return {bus.out_valid, bus.zero, bus.carry, bus.negative,
                bus.overflow, bus.illegal, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.sel      = op;
        bus.A        = a;
        bus.B        = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vecs++;
        if (flags() !== 7'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want %b", flags(), 7'b0);
        end
        vecs++;
        if (bus.result !== 8'h00) begin
            errs++;
            $display("FAIL reset_result got %h want 00", bus.result);
        end
        vecs++;
        if (bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        bus.out_ready = 1'b1;
        issue(3'b110, 8'h14, 8'h14);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_low_in_ready got %b want 0", bus.in_ready);
        end
        tick();
        vecs++;
        if (flags() !== 7'b0 || bus.result !== 8'h00) begin
            errs++;
            $display("FAIL mid_mul_reset got %b/%h want 0000000/00",
                     flags(), bus.result);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL mid_mul_ready got %b want 1", bus.in_ready);
        end
        issue(3'b000, 8'h01, 8'h01);
        vecs++;
        if (bus.result !== 8'h02 || flags() !== 7'b1000000) begin
            errs++;
            $display("FAIL add_after_rst got %h/%b want 02/1000000",
                     bus.result, flags());
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errs++;
                $display("FAIL stale_mul cyc %0d got ov=%b busy=%b want 0/0",
                         i, bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [2:0] op  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic [7:0] a   [4] = '{8'hC8, 8'h64, 8'h03, 8'h05};
        logic [7:0] b   [4] = '{8'h64, 8'h64, 8'h08, 8'h05};
        logic [7:0] r   [4] = '{8'h2C, 8'hC8, 8'hFB, 8'h00};
        logic [6:0] f   [4] = '{7'b1010000, 7'b1001100,
                                7'b1011000, 7'b1100000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(op[i], a[i], b[i]);
            vecs++;
            if (bus.result !== r[i] || flags() !== f[i]) begin
                errs++;
                $display("FAIL arith_%0d got %h/%b want %h/%b",
                         i, bus.result, flags(), r[i], f[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
        logic [7:0] r  [4] = '{8'h88, 8'hEE, 8'h44, 8'h66};
        logic [6:0] f  [4] = '{7'b1001000, 7'b1001000,
                               7'b1000000, 7'b1000000};
        bus.out_ready = 1'b1;
        bus.A         = 8'hCC;
        bus.B         = 8'hAA;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sel = op[i];
            #1;
            vecs++;
            if (bus.in_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_ready_%0d got %b want 1", i, bus.in_ready);
            end
            tick();
            vecs++;
            if (bus.result !== r[i] || flags() !== f[i]) begin
                errs++;
                $display("FAIL b2b_%0d got %h/%b want %h/%b",
                         i, bus.result, flags(), r[i], f[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        bus.out_ready = 1'b1;
        issue(3'b110, 8'h0D, 8'h0B);
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0
                || bus.out_valid !== 1'b0) begin
                errs++;
                $display("FAIL mul_busy cyc %0d got b=%b r=%b v=%b want 1/0/0",
                         i, bus.busy, bus.in_ready, bus.out_valid);
            end
            bus.in_valid = (i != 7);
            bus.sel      = 3'b000;
            bus.A        = 8'hFF;
            bus.B        = 8'hFF;
            tick();
        end
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.result !== 8'h8F || flags() !== 7'b1001000) begin
            errs++;
            $display("FAIL mul_0d_0b got %h/%b want 8F/1001000",
                     bus.result, flags());
        end
        tick();
        issue(3'b110, 8'h14, 8'h14);
        for (int i = 0; i < 8; i++) tick();
        vecs++;
        if (bus.result !== 8'h90 || flags() !== 7'b1011000) begin
            errs++;
            $display("FAIL mul_14_14 got %h/%b want 90/1011000",
                     bus.result, flags());
        end
        tick();
        issue(3'b110, 8'h00, 8'h37);
        for (int i = 0; i < 7; i++) tick();
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL mul_zero_early got v=%b b=%b want 0/1",
                     bus.out_valid, bus.busy);
        end
        tick();
        vecs++;
        if (bus.result !== 8'h00 || flags() !== 7'b1100000) begin
            errs++;
            $display("FAIL mul_zero got %h/%b want 00/1100000",
                     bus.result, flags());
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(3'b011, 8'h0F, 8'h30);
        bus.in_valid = 1'b1;
        bus.sel      = 3'b101;
        bus.A        = 8'h12;
        bus.B        = 8'h34;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (bus.result !== 8'h3F || flags() !== 7'b1000000
                || bus.in_ready !== 1'b0) begin
                errs++;
                $display("FAIL hold_%0d got %h/%b rdy=%b want 3F/1000000/0",
                         i, bus.result, flags(), bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        bus.sel       = 3'b111;
        bus.A         = 8'h05;
        bus.B         = 8'h03;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL release_ready got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.result !== 8'h00 || flags() !== 7'b1100010) begin
            errs++;
            $display("FAIL illegal_op got %h/%b want 00/1100010",
                     bus.result, flags());
        end
        tick();
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL drain got %b want 0", bus.out_valid);
        end
    endtask

    initial begin
        vecs          = 0;
        errs          = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_reset_mid_mul();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
